// File: rtl/regbank_access_ctrl.sv
// regbank_access_ctrl
//   Initiator-side controller for a 32x32 register bank. It accepts one
//   operand-fetch / write-back request at a time from decode. For each request
//   it issues a one-cycle read strobe, captures the RS/RT data and offers the
//   operands to execute. If the request needs write-back, it then waits for
//   the result and issues a one-cycle write strobe to RD.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and ready
//   are both high. A valid that the controller does not accept is not held
//   over. The controller keeps op_valid, op_a and op_b stable until op_ready
//   is seen. req_ready and wb_ready do not depend on the partner's valid.
//
//   Ports
//     clock, reset        rising-edge clock, synchronous active-high reset
//     req_*               decode request (rs, rt, rd, wb flag) with valid/ready
//     op_*                operands to execute with valid/ready
//     wb_*                write-back result from execute with valid/ready
//     rb_*                register bank addresses, strobes, write data, read data
//     retired_count       completed transactions, wraps at 2^CNT_WIDTH
//     fsm_state           current controller state, for observation only
//
//   Every output is a flop. The bank therefore sees strobes and addresses
//   with no combinational path from the request side.
module regbank_access_ctrl #(
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_rs,
  input  logic [4:0]           req_rt,
  input  logic [4:0]           req_rd,
  input  logic                 req_wb,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [31:0]          op_a,
  output logic [31:0]          op_b,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [31:0]          wb_data,
  output logic [4:0]           rb_rs,
  output logic [4:0]           rb_rt,
  output logic [4:0]           rb_rd,
  output logic                 rb_read_reg,
  output logic                 rb_write_reg,
  output logic [31:0]          rb_write_data,
  input  logic [31:0]          rb_data_1,
  input  logic [31:0]          rb_data_2,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [2:0]           fsm_state
);

  localparam bit ZERO_EN = (ZERO_REG_EN != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    DELIVER = 3'd2,
    WB_WAIT = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 wb_flag, wb_flag_nxt;
  logic                 req_ready_nxt;
  logic                 op_valid_nxt;
  logic [31:0]          op_a_nxt, op_b_nxt;
  logic                 wb_ready_nxt;
  logic [4:0]           rb_rs_nxt, rb_rt_nxt, rb_rd_nxt;
  logic                 rb_read_reg_nxt, rb_write_reg_nxt;
  logic [31:0]          rb_write_data_nxt;
  logic [CNT_WIDTH-1:0] retired_count_nxt;

  assign fsm_state = state;

  always_comb begin
    state_nxt         = state;
    wb_flag_nxt       = wb_flag;
    req_ready_nxt     = req_ready;
    op_valid_nxt      = op_valid;
    op_a_nxt          = op_a;
    op_b_nxt          = op_b;
    wb_ready_nxt      = wb_ready;
    rb_rs_nxt         = rb_rs;
    rb_rt_nxt         = rb_rt;
    rb_rd_nxt         = rb_rd;
    rb_read_reg_nxt   = 1'b0;
    rb_write_reg_nxt  = 1'b0;
    rb_write_data_nxt = rb_write_data;
    retired_count_nxt = retired_count;

    case (state)
      IDLE: begin
        if (req_valid) begin
          // Addresses are latched only here, so they stay stable for the whole transaction.
          rb_rs_nxt       = req_rs;
          rb_rt_nxt       = req_rt;
          rb_rd_nxt       = req_rd;
          wb_flag_nxt     = req_wb;
          req_ready_nxt   = 1'b0;
          rb_read_reg_nxt = 1'b1;
          state_nxt       = READ;
        end
      end

      READ: begin
        // The bank data belongs to the addresses presented during this strobe cycle.
        op_a_nxt     = (ZERO_EN && rb_rs == 5'd0) ? 32'd0 : rb_data_1;
        op_b_nxt     = (ZERO_EN && rb_rt == 5'd0) ? 32'd0 : rb_data_2;
        op_valid_nxt = 1'b1;
        state_nxt    = DELIVER;
      end

      DELIVER: begin
        if (op_ready) begin
          op_valid_nxt = 1'b0;
          if (wb_flag) begin
            wb_ready_nxt = 1'b1;
            state_nxt    = WB_WAIT;
          end else begin
            req_ready_nxt     = 1'b1;
            retired_count_nxt = retired_count + CNT_WIDTH'(1);
            state_nxt         = IDLE;
          end
        end
      end

      WB_WAIT: begin
        if (wb_valid) begin
          rb_write_data_nxt = wb_data;
          wb_ready_nxt      = 1'b0;
          if (ZERO_EN && rb_rd == 5'd0) begin
            // Register 0 is read-only. The result is dropped, but the transaction still retires.
            req_ready_nxt     = 1'b1;
            retired_count_nxt = retired_count + CNT_WIDTH'(1);
            state_nxt         = IDLE;
          end else begin
            rb_write_reg_nxt = 1'b1;
            state_nxt        = WRITE;
          end
        end
      end

      WRITE: begin
        req_ready_nxt     = 1'b1;
        retired_count_nxt = retired_count + CNT_WIDTH'(1);
        state_nxt         = IDLE;
      end

      default: begin
        req_ready_nxt = 1'b1;
        op_valid_nxt  = 1'b0;
        wb_ready_nxt  = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wb_flag       <= 1'b0;
      req_ready     <= 1'b1;
      op_valid      <= 1'b0;
      op_a          <= 32'd0;
      op_b          <= 32'd0;
      wb_ready      <= 1'b0;
      rb_rs         <= 5'd0;
      rb_rt         <= 5'd0;
      rb_rd         <= 5'd0;
      rb_read_reg   <= 1'b0;
      rb_write_reg  <= 1'b0;
      rb_write_data <= 32'd0;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      wb_flag       <= wb_flag_nxt;
      req_ready     <= req_ready_nxt;
      op_valid      <= op_valid_nxt;
      op_a          <= op_a_nxt;
      op_b          <= op_b_nxt;
      wb_ready      <= wb_ready_nxt;
      rb_rs         <= rb_rs_nxt;
      rb_rt         <= rb_rt_nxt;
      rb_rd         <= rb_rd_nxt;
      rb_read_reg   <= rb_read_reg_nxt;
      rb_write_reg  <= rb_write_reg_nxt;
      rb_write_data <= rb_write_data_nxt;
      retired_count <= retired_count_nxt;
    end
  end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Testbench for regbank_access_ctrl. The DUT uses a 2-bit counter so that
// counter wrap-around is exercised. A register-bank model is attached to the
// rb_* port. Reference expectations come from a separate reference bank that
// is updated only when the test plan says a write happens.
module tb_regbank_access_ctrl;

  localparam int CW = 2;

  logic          clock, reset;
  logic          req_valid, req_ready, req_wb;
  logic [4:0]    req_rs, req_rt, req_rd;
  logic          op_valid, op_ready;
  logic [31:0]   op_a, op_b;
  logic          wb_valid, wb_ready;
  logic [31:0]   wb_data;
  logic [4:0]    rb_rs, rb_rt, rb_rd;
  logic          rb_read_reg, rb_write_reg;
  logic [31:0]   rb_write_data, rb_data_1, rb_data_2;
  logic [CW-1:0] retired_count;
  logic [2:0]    fsm_state;

  regbank_access_ctrl #(.ZERO_REG_EN(1), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wb(req_wb),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .rb_rs(rb_rs), .rb_rt(rb_rt), .rb_rd(rb_rd),
    .rb_read_reg(rb_read_reg), .rb_write_reg(rb_write_reg),
    .rb_write_data(rb_write_data), .rb_data_1(rb_data_1), .rb_data_2(rb_data_2),
    .retired_count(retired_count), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bank model ----------------
  logic [31:0] bank [32];
  assign rb_data_1 = bank[rb_rs];
  assign rb_data_2 = bank[rb_rt];
  always @(posedge clock) if (rb_write_reg) bank[rb_rd] <= rb_write_data;

  // ---------------- reference state and scoreboard ----------------
  logic [31:0] ref_bank [32];
  logic [63:0] exp_q[$];   // {op_a, op_b} expected at each operand handshake
  logic [36:0] wr_q[$];    // {rd, data} expected at each write strobe
  int          exp_cnt;
  int          total, bad;
  logic        prev_strobe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled there or on the falling edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (rb_read_reg || rb_write_reg) begin
        check("strobe_overlap", 64'(rb_read_reg & rb_write_reg), 64'd0);
        check("strobe_gap", 64'(prev_strobe), 64'd0);
      end
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL op_unexpected: got %h%h expected none", op_a, op_b);
        end else begin
          check("operands", {op_a, op_b}, exp_q.pop_front());
        end
      end
      if (rb_write_reg) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL write_unexpected: got rd=%0d data=%h expected none", rb_rd, rb_write_data);
        end else begin
          check("write", 64'({rb_rd, rb_write_data}), 64'(wr_q.pop_front()));
        end
      end
      prev_strobe = rb_read_reg | rb_write_reg;
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_op_valid", 64'(op_valid), 64'd0);
    check("rst_wb_ready", 64'(wb_ready), 64'd0);
    check("rst_strobes", 64'({rb_read_reg, rb_write_reg}), 64'd0);
    check("rst_ops", {op_a, op_b}, 64'd0);
    check("rst_addr", 64'({rb_rs, rb_rt, rb_rd}), 64'd0);
    check("rst_wdata", 64'(rb_write_data), 64'd0);
    check("rst_count", 64'(retired_count), 64'd0);
    exp_cnt = 0;
    reset = 1'b0;
    step();
  endtask

  task automatic do_txn(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic wb, input logic [31:0] wdata,
                        input int op_dly, input int wb_dly, input bit abort);
    logic [31:0] ea, eb;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("idle_ready", 64'(req_ready), 64'd1);
    ea = (rs == 5'd0) ? 32'd0 : ref_bank[rs];
    eb = (rt == 5'd0) ? 32'd0 : ref_bank[rt];
    exp_q.push_back({ea, eb});
    req_valid = 1'b1; req_rs = rs; req_rt = rt; req_rd = rd; req_wb = wb;
    step();
    // Scramble the request fields so that any address which is not held would corrupt the result.
    req_valid = 1'b0; req_rs = ~rs; req_rt = ~rt; req_rd = ~rd; req_wb = ~wb;
    check("read_strobe", 64'(rb_read_reg), 64'd1);
    check("busy", 64'(req_ready), 64'd0);
    step();
    check("read_strobe_once", 64'(rb_read_reg), 64'd0);
    check("op_valid_latency", 64'(op_valid), 64'd1);
    for (int i = 0; i < op_dly; i++) begin
      op_ready = 1'b0;
      req_valid = (i % 2 == 0);
      check("hold_valid", 64'(op_valid), 64'd1);
      check("hold_ops", {op_a, op_b}, {ea, eb});
      check("req_ignored", 64'(req_ready), 64'd0);
      step();
    end
    req_valid = 1'b0;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("op_valid_drop", 64'(op_valid), 64'd0);
    if (wb) begin
      check("wb_ready", 64'(wb_ready), 64'd1);
      if (abort) begin
        reset = 1'b1;
        step();
        check("abort_idle", 64'({req_ready, op_valid, wb_ready}), 64'b100);
        check("abort_strobes", 64'({rb_read_reg, rb_write_reg}), 64'd0);
        check("abort_count", 64'(retired_count), 64'd0);
        exp_cnt = 0;
        reset = 1'b0;
        step();
        return;
      end
      for (int j = 0; j < wb_dly; j++) begin
        step();
        check("wb_ready_held", 64'(wb_ready), 64'd1);
      end
      wb_valid = 1'b1;
      wb_data = wdata;
      if (rd != 5'd0) begin
        wr_q.push_back({rd, wdata});
        ref_bank[rd] = wdata;
      end
      step();
      wb_valid = 1'b0;
      wb_data = $urandom;
      check("wb_ready_drop", 64'(wb_ready), 64'd0);
      if (rd != 5'd0) begin
        check("write_strobe", 64'(rb_write_reg), 64'd1);
        step();
      end else begin
        check("no_write_r0", 64'(rb_write_reg), 64'd0);
      end
    end
    exp_cnt++;
    check("retired_count", 64'(retired_count), 64'(exp_cnt % (1 << CW)));
    check("back_idle", 64'({req_ready, rb_write_reg}), 64'b10);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0; exp_cnt = 0; prev_strobe = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0; req_wb = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_data = '0;
    for (int i = 0; i < 32; i++) begin
      bank[i] = $urandom;
    end
    bank[0] = 32'hDEAD_BEEF;
    bank[5] = 32'h1111_0005;
    bank[9] = 32'hAAAA_0009;
    for (int i = 0; i < 32; i++) ref_bank[i] = bank[i];

    do_reset();

    // The directed cases come from the test plan.
    do_txn(5'd5, 5'd9, 5'd3, 1'b0, 32'h0, 0, 0, 1'b0);
    do_txn(5'd0, 5'd0, 5'd3, 1'b0, 32'h0, 0, 0, 1'b0);
    do_txn(5'd4, 5'd5, 5'd7, 1'b1, 32'h1234_5678, 0, 3, 1'b0);
    do_txn(5'd7, 5'd7, 5'd1, 1'b0, 32'h0, 0, 0, 1'b0);
    do_txn(5'd2, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0);
    do_txn(5'd9, 5'd5, 5'd9, 1'b1, 32'h0BAD_F00D, 4, 1, 1'b0);
    do_txn(5'd3, 5'd6, 5'd8, 1'b1, 32'h5555_AAAA, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) do_txn(5'(k + 1), 5'(k + 2), 5'd0, 1'b0, 32'h0, 0, 0, 1'b0);
    check("count_after_five", 64'(retired_count), 64'd1);

    // Random requests
    for (int k = 0; k < 40; k++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      do_txn(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rd,
             1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    step();
    step();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
